scan_cmd_frontend: RTL

- Serial-to-parallel command front end for one scan group.
- Sits directly upstream of the group scan memory/register interface: it drives that block's `static_*` request port and `scan_id`.
- A command frame is shifted in serially, then issued as one write or read transaction on `scan_update`. On completion, status and read data are loaded back into the shift register so they can be shifted out.

---
 rtl/scan_cmd_frontend_if.sv | 36 +++
 rtl/scan_cmd_frontend.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/scan_cmd_frontend_if.sv
// Request/response bus between scan_cmd_frontend and the group scan
// memory/register block, together with the group select scan_id.
interface scan_cmd_frontend_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    logic              static_wen;
    logic              static_ren;
    logic [ADDR_W-1:0] static_addr;
    logic [DATA_W-1:0] static_wdata;
    logic [DATA_W-1:0] static_rdata;
    logic              static_ready;
    logic              scan_id;

    // Command front end side: issues requests, receives completion.
    modport master (
        output static_wen,
        output static_ren,
        output static_addr,
        output static_wdata,
        output scan_id,
        input  static_rdata,
        input  static_ready
    );

    // Memory/register side: receives requests, returns completion.
    modport slave (
        input  static_wen,
        input  static_ren,
        input  static_addr,
        input  static_wdata,
        input  scan_id,
        output static_rdata,
        output static_ready
    );
endinterface

// File: rtl/scan_cmd_frontend.sv
// Serial-to-parallel command front end for one scan group.
// A frame {wdata, addr, op} is shifted in LSB first, issued on scan_update as
// one write or read on the static_* bus, and the response
// {rdata_or_zero, addr, status} is loaded back into the shift register.
// Optional feature: define SCAN_CMD_TIMEOUT_EN to bound the wait for
// static_ready to TIMEOUT cycles (status 2'b10 on expiry).
module scan_cmd_frontend #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                scan_in,
    input  logic                scan_en,
    input  logic                scan_update,
    output logic                scan_out,
    output logic                busy,
    scan_cmd_frontend_if.master bus
);
    localparam int F = 2 + ADDR_W + DATA_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] ST_OK = 2'b01;
    localparam logic [1:0] ST_TO = 2'b10;

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("scan_cmd_frontend: TIMEOUT must be at least 1");
    end

    logic [1:0]        state;
    logic [F-1:0]      sr;
    logic              is_read;
    logic              ready_seen;

    logic [1:0]        fr_op;
    logic [ADDR_W-1:0] fr_addr;
    logic [DATA_W-1:0] fr_wdata;
    logic              cmd_valid;
    logic              ready_now;
    logic              timed_out;
    logic [DATA_W-1:0] resp_data;
    logic [1:0]        resp_status;
    logic [F-1:0]      resp_frame;

    assign fr_op     = sr[1:0];
    assign fr_addr   = sr[ADDR_W+1:2];
    assign fr_wdata  = sr[F-1:ADDR_W+2];
    assign cmd_valid = (fr_op == OP_WR) || (fr_op == OP_RD);

    // A ready seen during ISSUE is remembered so a one-cycle pulse there
    // still completes the transaction in the following WAIT cycle.
    assign ready_now = bus.static_ready || ready_seen;

    assign scan_out = sr[0];
    assign busy     = (state != S_IDLE);

`ifdef SCAN_CMD_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;

    // Count WAIT cycles; the last allowed one is numbered TIMEOUT-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == S_ISSUE) begin
            wait_cnt <= '0;
        end else if ((state == S_WAIT) && !ready_now && !timed_out) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Ready in the final WAIT cycle takes precedence over the timeout.
    assign timed_out = (state == S_WAIT) && !ready_now && (wait_cnt == CNT_LAST);
`else
    assign timed_out = 1'b0;
`endif

    // Response frame loaded into the shift register on completion.
    always_comb begin
        resp_data   = '0;
        resp_status = ST_TO;
        if (ready_now) begin
            resp_status = ST_OK;
            if (is_read) begin
                resp_data = bus.static_rdata;
            end
        end
        resp_frame = {resp_data, bus.static_addr, resp_status};
    end

    // Command FSM, shift register and registered request outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            sr               <= '0;
            is_read          <= 1'b0;
            ready_seen       <= 1'b0;
            bus.static_wen   <= 1'b0;
            bus.static_ren   <= 1'b0;
            bus.static_addr  <= '0;
            bus.static_wdata <= '0;
            bus.scan_id      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (scan_en) begin
                        sr <= {scan_in, sr[F-1:1]};
                    end else if (scan_update && cmd_valid) begin
                        state            <= S_ISSUE;
                        is_read          <= (fr_op == OP_RD);
                        bus.static_wen   <= (fr_op == OP_WR);
                        bus.static_ren   <= (fr_op == OP_RD);
                        bus.static_addr  <= fr_addr;
                        bus.static_wdata <= fr_wdata;
                        bus.scan_id      <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    ready_seen <= bus.static_ready;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (ready_now || timed_out) begin
                        state          <= S_DONE;
                        sr             <= resp_frame;
                        bus.static_wen <= 1'b0;
                        bus.static_ren <= 1'b0;
                        bus.scan_id    <= 1'b0;
                    end
                end
                default: begin
                    ready_seen <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end
endmodule
